// File: rtl/irb_scan_pkg.sv
// Shared types and defaults for the IRB scan-out stage.
package irb_scan_pkg;

  localparam int IMG_W_DEF  = 8;
  localparam int IMG_H_DEF  = 8;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;
  localparam int FRAME_PIX  = IMG_W_DEF * IMG_H_DEF;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irb_scan_skid.sv
// Two-entry valid/ready skid buffer with empty bypass.
module irb_scan_skid #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occ
);

  logic [W-1:0] mem [2];
  logic         rp;
  logic         wp;
  logic [1:0]   cnt;
  logic         empty;
  logic         push;
  logic         pop;

  assign empty = (cnt == 2'd0);
  assign occ   = cnt;

  // When empty, incoming data is presented the same cycle it arrives.
  assign out_valid = empty ? in_valid : 1'b1;
  assign out_data  = !empty ? mem[rp] :
                     in_valid ? in_data : '0;

  assign pop  = !empty && out_ready;
  assign push = in_valid && !(empty && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rp     <= 1'b0;
      wp     <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= in_data;
        wp      <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/irb_scan_out.sv
// Streams the finished 8x8 IRB image out in raster order with sof/eol tags.
// Optional frame checksum output: define IRB_SCAN_CKSUM_EN.
module irb_scan_out
  import irb_scan_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] IRB_Q,
  output logic              IRB_CEN,
  output logic              IRB_WEN,
  output logic [ADDR_W-1:0] IRB_A,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
`ifdef IRB_SCAN_CKSUM_EN
  output logic [15:0]       frame_cksum,
`endif
  output logic              frame_done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = clog2_min1(IMG_W);
  localparam int OW   = $clog2(NPIX + 1);
  localparam int SW   = DATA_W + 2;

  state_e            state;
  state_e            nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic [CW-1:0]     rd_col;
  logic [OW-1:0]     out_cnt;
  logic              inflight;
  logic              inf_sof;
  logic              inf_eol;
  logic [1:0]        occ;
  logic [1:0]        pending;
  logic              accept;
  logic              issue;
  logic              last_issue;
  logic              fire;
  logic              last_xfer;
  logic [SW-1:0]     head;

  // Occupancy plus the read in flight bounds what the buffer can still absorb.
  assign pending    = occ + {1'b0, inflight};
  assign accept     = (state == IDLE) && start;
  assign issue      = (state == SCAN) && (pending < 2'd2);
  assign last_issue = issue && (rd_addr == ADDR_W'(NPIX - 1));
  assign fire       = pix_valid && pix_ready;
  assign last_xfer  = fire && (out_cnt == OW'(NPIX - 1));

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = SCAN;
      SCAN:  if (last_issue) nxt = DRAIN;
      DRAIN: if (last_xfer) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rd_addr  <= '0;
      rd_col   <= '0;
      out_cnt  <= '0;
      inflight <= 1'b0;
      inf_sof  <= 1'b0;
      inf_eol  <= 1'b0;
    end else begin
      state    <= nxt;
      inflight <= issue;
      if (issue) begin
        inf_sof <= (rd_addr == '0);
        inf_eol <= (rd_col == CW'(IMG_W - 1));
      end
      if (accept) begin
        rd_addr <= '0;
        rd_col  <= '0;
      end else if (issue && !last_issue) begin
        rd_addr <= rd_addr + 1'b1;
        rd_col  <= (rd_col == CW'(IMG_W - 1)) ? '0 : rd_col + 1'b1;
      end else if (state == DONE) begin
        rd_addr <= '0;
      end
      if (accept) out_cnt <= '0;
      else if (fire) out_cnt <= out_cnt + 1'b1;
    end
  end

  irb_scan_skid #(
    .W(SW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .in_valid (inflight),
    .in_data  ({inf_sof, inf_eol, IRB_Q}),
    .out_valid(pix_valid),
    .out_data (head),
    .out_ready(pix_ready),
    .occ      (occ)
  );

  assign pix_sof    = head[SW-1];
  assign pix_eol    = head[SW-2];
  assign pix_data   = head[DATA_W-1:0];
  assign IRB_CEN    = ~issue;
  assign IRB_WEN    = 1'b1;
  assign IRB_A      = rd_addr;
  assign busy       = (state == SCAN) || (state == DRAIN) || accept;
  assign frame_done = (state == DONE);

`ifdef IRB_SCAN_CKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cksum <= '0;
    else if (accept) frame_cksum <= '0;
    else if (fire) frame_cksum <= frame_cksum + 16'(pix_data);
  end
`endif

endmodule

// File: tb/tb_irb_scan_out.sv
// Self-checking bench for irb_scan_out: vector table plus randomized stream model.
module tb_irb_scan_out;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        pix_ready;
  logic [7:0]  irb_q = 8'd0;
  logic        irb_cen;
  logic        irb_wen;
  logic [5:0]  irb_a;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_eol;
  logic        busy;
  logic        frame_done;
`ifdef IRB_SCAN_CKSUM_EN
  logic [15:0] frame_cksum;
`endif

  logic [7:0] mem [64];
  int vec = 0;
  int bad = 0;

  typedef struct {
    int         k;
    logic       valid;
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       cen;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tab [9];

  irb_scan_out dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .IRB_Q      (irb_q),
    .IRB_CEN    (irb_cen),
    .IRB_WEN    (irb_wen),
    .IRB_A      (irb_a),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .busy       (busy),
`ifdef IRB_SCAN_CKSUM_EN
    .frame_cksum(frame_cksum),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!irb_cen) irb_q <= mem[irb_a];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  task automatic check_rst(input string nm);
    chk(nm, 32'({irb_cen, irb_wen, irb_a, pix_data, pix_valid,
                 pix_sof, pix_eol, busy, frame_done}),
        32'({1'b1, 1'b1, 6'd0, 8'd0, 5'b00000}));
`ifdef IRB_SCAN_CKSUM_EN
    chk({nm, "_cksum"}, 32'(frame_cksum), 32'd0);
`endif
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
  endtask

  // One frame: stream must be mem[0..63] in order with sof/eol from the index.
  task automatic run_frame(input int pct, input int restart_px,
                           input int stall_k, input bit use_tab);
    int         xi;
    int         issued;
    bit         pend;
    bit         restarted;
    bit         seen_done;
    logic [9:0] held;
    logic [15:0] sum;
    xi = 0;
    issued = 0;
    pend = 0;
    restarted = 0;
    seen_done = 0;
    held = '0;
    sum = '0;
    for (int k = 0; k < 3000 && !seen_done; k++) begin
      @(negedge clk);
      start = (k == 0);
      if (k > 0 && restart_px >= 0 && !restarted && xi == restart_px) begin
        start = 1'b1;
        restarted = 1;
      end
      pix_ready = (k < stall_k) ? 1'b0 : ($urandom_range(99) < pct);
      #1;
      if (use_tab)
        foreach (tab[i])
          if (tab[i].k == k)
            chk($sformatf("tab_k%0d", k),
                32'({pix_valid, pix_data, pix_sof, pix_eol, irb_cen,
                     busy, frame_done}),
                32'({tab[i].valid, tab[i].data, tab[i].sof, tab[i].eol,
                     tab[i].cen, tab[i].busy, tab[i].done}));
      if (pend)
        chk("hold", 32'({pix_valid, pix_sof, pix_eol, pix_data}),
            32'({1'b1, held}));
      pend = pix_valid && !pix_ready;
      held = {pix_sof, pix_eol, pix_data};
      if (k >= 2 && k < stall_k)
        chk("stall_head", 32'({pix_valid, pix_sof, pix_data}),
            32'({1'b1, 1'b1, mem[0]}));
      if (k >= 4 && k < stall_k)
        chk("stall_cen", 32'(irb_cen), 32'd1);
      if (!irb_cen) begin
        chk("issue_gate", 32'(issued - xi < 2), 32'd1);
        chk("issue_addr", 32'(irb_a), 32'(issued));
        issued++;
      end
      if (pix_valid && pix_ready) begin
        chk("pixel_count", 32'(xi < 64), 32'd1);
        chk("pixel", 32'({pix_sof, pix_eol, pix_data}),
            32'({xi == 0, xi % 8 == 7, mem[xi[5:0]]}));
        sum = sum + 16'(mem[xi[5:0]]);
        xi++;
      end
      if (frame_done) begin
        seen_done = 1;
        chk("done_xfers", 32'(xi), 32'd64);
        chk("done_busy", 32'(busy), 32'd0);
`ifdef IRB_SCAN_CKSUM_EN
        chk("cksum_model", 32'(frame_cksum), 32'(sum));
`endif
      end else begin
        chk("busy", 32'(busy), 32'd1);
      end
    end
    chk("frame_timeout", 32'(seen_done), 32'd1);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("idle", 32'({busy, frame_done, pix_valid, irb_cen}), 32'(4'b0001));
    end
  endtask

  initial begin
    bit found;
    reset = 1'b0;
    start = 1'b0;
    pix_ready = 1'b0;
    fill_ramp();
    tab[0] = '{0,  1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tab[1] = '{1,  1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[2] = '{2,  1'b1, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[3] = '{3,  1'b1, 8'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[4] = '{9,  1'b1, 8'd7,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tab[5] = '{10, 1'b1, 8'd8,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[6] = '{64, 1'b1, 8'd62, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tab[7] = '{65, 1'b1, 8'd63, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tab[8] = '{66, 1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    #1 check_rst("reset");
    @(negedge clk);
    reset = 1'b1;
    #1 check_rst("post_reset");

    run_frame(100, -1, 0, 1);

    run_frame(50, -1, 0, 0);
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    run_frame(50, -1, 0, 0);
    fill_ramp();

    run_frame(100, 10, 0, 0);

    found = 0;
    @(negedge clk);
    start = 1'b1;
    pix_ready = 1'b1;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (pix_valid && pix_data == 8'd20) found = 1;
    end
    chk("find_px20", 32'(found), 32'd1);
    reset = 1'b0;
    #1 check_rst("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    #1 check_rst("rst_release");
    run_frame(100, -1, 0, 0);

    run_frame(100, -1, 12, 0);

`ifdef IRB_SCAN_CKSUM_EN
    for (int i = 0; i < 64; i++) mem[i] = 8'hFF;
    run_frame(100, -1, 0, 0);
    chk("cksum_ff", 32'(frame_cksum), 32'h3FC0);
    fill_ramp();
    run_frame(60, -1, 0, 0);
    chk("cksum_ramp", 32'(frame_cksum), 32'h07E0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
